// File: rtl/sp_ram_pm_banked_if.sv
// ============================================================================
// Module      : sp_ram_pm_banked_if
// Description : Request/grant/response bus between a memory requester and the
//               banked, power-managed single-port RAM wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sp_ram_pm_banked_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32
);
   logic                    req_i;
   logic                    gnt_o;
   logic [ADDR_WIDTH-1:0]   addr_i;
   logic                    we_i;
   logic [DATA_WIDTH/8-1:0] be_i;
   logic [DATA_WIDTH-1:0]   wdata_i;
   logic                    rvalid_o;
   logic [DATA_WIDTH-1:0]   rdata_o;

   // Requester side
   modport master (
      output req_i, addr_i, we_i, be_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o
   );

   // Memory side
   modport slave (
      input  req_i, addr_i, we_i, be_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o
   );
endinterface

`default_nettype wire

// File: rtl/sp_ram_pm_banked.sv
// ============================================================================
// Module      : sp_ram_pm_banked
// Description : Single-port SRAM split into NUM_BANKS contiguous banks with a
//               req/gnt/rvalid handshake. Each bank drops into retention
//               sleep after IDLE_CYCLES untouched cycles and needs
//               WAKE_CYCLES cycles of wake-up before it grants again.
//               Optional macro RAM_BYPASS_EN adds the bypass_en_i test port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sp_ram_pm_banked #(
   parameter int RAM_SIZE    = 32768,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_BANKS   = 4,
   parameter int ADDR_WIDTH  = $clog2(RAM_SIZE),
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2
) (
   input  wire logic                 clk,
   input  wire logic                 rstn_i,
   sp_ram_pm_banked_if.slave         bus,
   output logic [NUM_BANKS-1:0]      sleep_o
`ifdef RAM_BYPASS_EN
   ,
   input  wire logic                 bypass_en_i
`endif
);

   localparam int BE_W       = DATA_WIDTH / 8;
   localparam int OFF_BITS   = $clog2(BE_W);
   localparam int BANK_BITS  = $clog2(NUM_BANKS);
   localparam int SEL_W      = (BANK_BITS > 0) ? BANK_BITS : 1;
   localparam int IDX_W      = ADDR_WIDTH - BANK_BITS - OFF_BITS;
   localparam int BANK_WORDS = 1 << IDX_W;
   localparam int CNT_MAX    = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
   localparam int CNT_W      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_SLEEP  = 2'd1,
      ST_WAKE   = 2'd2
   } bank_state_t;

   logic [SEL_W-1:0]            bank_sel;
   logic [IDX_W-1:0]            word_idx;
   logic [NUM_BANKS-1:0]        bank_hit;
   logic                        bypass;
   logic                        gnt;
   logic                        wr_en;
   logic                        rd_en;

   bank_state_t                 state_q [NUM_BANKS];
   bank_state_t                 state_d [NUM_BANKS];
   logic [CNT_W-1:0]            cnt_q   [NUM_BANKS];
   logic [CNT_W-1:0]            cnt_d   [NUM_BANKS];

   logic                        rvalid_q, rvalid_d;
   logic                        rsp_mem_q, rsp_mem_d;
   logic [SEL_W-1:0]            rsp_bank_q, rsp_bank_d;
   logic [NUM_BANKS*DATA_WIDTH-1:0] rd_flat;

   // ------------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------------
   if (BANK_BITS > 0) begin : g_bank_sel
      assign bank_sel = bus.addr_i[ADDR_WIDTH-1 -: BANK_BITS];
   end else begin : g_single_bank
      assign bank_sel = '0;
   end

   assign word_idx = bus.addr_i[OFF_BITS +: IDX_W];

   // Byte-offset bits never select anything; fold them away explicitly
   if (OFF_BITS > 0) begin : g_off_unused
      logic unused_off;
      assign unused_off = ^bus.addr_i[OFF_BITS-1:0];
   end

`ifdef RAM_BYPASS_EN
   assign bypass = bypass_en_i;
`else
   assign bypass = 1'b0;
`endif

   // One-hot "request addresses bank b" vector
   always_comb begin
      bank_hit           = '0;
      bank_hit[bank_sel] = bus.req_i;
   end

   // Only an ACTIVE bank may grant; sleeping/waking banks hold the requester off
   assign gnt   = bus.req_i && (state_q[bank_sel] == ST_ACTIVE);
   assign wr_en = gnt && bus.we_i && !bypass;
   assign rd_en = gnt && !bus.we_i && !bypass;

   assign bus.gnt_o = gnt;

   // ------------------------------------------------------------------------
   // Per-bank power FSM
   // ------------------------------------------------------------------------
   // Next-state and counter logic for every bank
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         state_d[b] = state_q[b];
         cnt_d[b]   = cnt_q[b];
         case (state_q[b])
            ST_ACTIVE: begin
               if (bank_hit[b]) begin
                  // A hit wins over the idle timeout in the same cycle
                  cnt_d[b] = '0;
               end else if (IDLE_CYCLES != 0) begin
                  if (cnt_q[b] == CNT_W'(IDLE_CYCLES - 1)) begin
                     state_d[b] = ST_SLEEP;
                     cnt_d[b]   = '0;
                  end else begin
                     cnt_d[b] = cnt_q[b] + 1'b1;
                  end
               end
            end
            ST_SLEEP: begin
               if (bank_hit[b]) begin
                  state_d[b] = ST_WAKE;
                  cnt_d[b]   = CNT_W'(WAKE_CYCLES);
               end
            end
            ST_WAKE: begin
               if (cnt_q[b] <= CNT_W'(1)) begin
                  state_d[b] = ST_ACTIVE;
                  cnt_d[b]   = '0;
               end else begin
                  cnt_d[b] = cnt_q[b] - 1'b1;
               end
            end
            default: begin
               state_d[b] = ST_ACTIVE;
               cnt_d[b]   = '0;
            end
         endcase
      end
   end

   // Bank state registers; reset returns every bank to ACTIVE immediately
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            state_q[b] <= ST_ACTIVE;
            cnt_q[b]   <= '0;
         end
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            state_q[b] <= state_d[b];
            cnt_q[b]   <= cnt_d[b];
         end
      end
   end

   // Sleep status: anything other than ACTIVE counts as powered down
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         sleep_o[b] = (state_q[b] != ST_ACTIVE);
      end
   end

   // ------------------------------------------------------------------------
   // Storage: one array per bank, synchronous read, byte-masked write.
   // No reset on the arrays so contents survive sleep and reset alike.
   // ------------------------------------------------------------------------
   for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [BANK_WORDS];
      logic [DATA_WIDTH-1:0] rd_word_q;
      logic                  bank_wr;
      logic                  bank_rd;

      assign bank_wr = wr_en && (bank_sel == SEL_W'(gb));
      assign bank_rd = rd_en && (bank_sel == SEL_W'(gb));

      // Byte-enabled write port and registered read port of this bank
      always_ff @(posedge clk) begin
         if (bank_wr) begin
            for (int i = 0; i < BE_W; i++) begin
               if (bus.be_i[i]) begin
                  mem[word_idx][i*8 +: 8] <= bus.wdata_i[i*8 +: 8];
               end
            end
         end
         if (bank_rd) begin
            rd_word_q <= mem[word_idx];
         end
      end

      assign rd_flat[gb*DATA_WIDTH +: DATA_WIDTH] = rd_word_q;
   end

   // ------------------------------------------------------------------------
   // Response path: one rvalid pulse per grant, one cycle later
   // ------------------------------------------------------------------------
   // Capture what kind of response the granted transaction needs
   always_comb begin
      rvalid_d   = gnt;
      rsp_mem_d  = rd_en;
      rsp_bank_d = rd_en ? bank_sel : rsp_bank_q;
   end

   // Response registers; reset drops any pending response at once
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         rvalid_q   <= 1'b0;
         rsp_mem_q  <= 1'b0;
         rsp_bank_q <= '0;
      end else begin
         rvalid_q   <= rvalid_d;
         rsp_mem_q  <= rsp_mem_d;
         rsp_bank_q <= rsp_bank_d;
      end
   end

   assign bus.rvalid_o = rvalid_q;

`ifdef RAM_BYPASS_EN
   logic                  rsp_byp_q, rsp_byp_d;
   logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

   // Bypass echoes this cycle's write data for any granted transaction
   always_comb begin
      rsp_byp_d  = gnt && bypass;
      byp_data_d = (gnt && bypass) ? bus.wdata_i : byp_data_q;
   end

   // Bypass response registers
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         rsp_byp_q  <= 1'b0;
         byp_data_q <= '0;
      end else begin
         rsp_byp_q  <= rsp_byp_d;
         byp_data_q <= byp_data_d;
      end
   end

   assign bus.rdata_o = !rvalid_q  ? '0 :
                        rsp_byp_q  ? byp_data_q :
                        rsp_mem_q  ? rd_flat[rsp_bank_q*DATA_WIDTH +: DATA_WIDTH] :
                                     '0;
`else
   assign bus.rdata_o = (rvalid_q && rsp_mem_q) ?
                        rd_flat[rsp_bank_q*DATA_WIDTH +: DATA_WIDTH] : '0;
`endif

endmodule

`default_nettype wire

// File: doc/sp_ram_pm_banked.md
# sp_ram_pm_banked

Parametrised single-port SRAM wrapper that splits the RAM into NUM_BANKS contiguous banks, adds a req/gnt/rvalid handshake, and puts idle banks into a retention sleep state with a counted wake-up. Sits between the AXI-to-memory bridge and the physical RAM macros, replacing the fixed-size, always-on single-port wrapper for instruction and data memories.

## Interface
- RAM_SIZE, 32768, total capacity in bytes; power of two.
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- NUM_BANKS, 4, number of contiguous banks; power of two, at least 1.
- ADDR_WIDTH, $clog2(RAM_SIZE), byte address width.
- IDLE_CYCLES, 16, consecutive untouched cycles before a bank sleeps; 0 disables sleep.
- WAKE_CYCLES, 2, cycles spent in WAKE before a bank accepts access; at least 1.
- clk  in  1  clock; single clock domain.
- rstn_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  access request.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  ADDR_WIDTH  byte address.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  DATA_WIDTH/8  byte enables for writes.
- wdata_i  in  DATA_WIDTH  write data.
- rvalid_o  out  1  response for the transaction granted in the previous cycle.
- rdata_o  out  DATA_WIDTH  read data, valid while rvalid_o is high.
- sleep_o  out  NUM_BANKS  bit b = bank b is in SLEEP or WAKE.
- bypass_en_i  in  1  test bypass; present only with RAM_BYPASS_EN.

## Operation
- Bank select: addr_i[ADDR_WIDTH-1 -: $clog2(NUM_BANKS)]; word index: addr_i bits below that, above $clog2(DATA_WIDTH/8). Low byte-offset bits ignored.
- gnt_o = req_i & (selected bank state == ACTIVE); combinational.
- Granted write: bytes with be_i set are written; others keep contents. Granted read: word returned next cycle.
- Every granted transaction produces exactly one rvalid_o pulse one cycle later; for writes rdata_o = 0.
- Per-bank FSM (states ACTIVE, SLEEP, WAKE), counter width $clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1):
  - ACTIVE: counter clears on any req_i to this bank, else increments; when counter reaches IDLE_CYCLES -> SLEEP. Never leaves ACTIVE if IDLE_CYCLES == 0.
  - SLEEP: req_i addressing this bank -> WAKE, counter loaded with WAKE_CYCLES; gnt_o low.
  - WAKE: counter decrements each cycle; at 1 -> ACTIVE with counter 0; gnt_o low; req_i ignored for state.
- Contents are retained through SLEEP/WAKE.
- Requester must hold req_i, addr_i, we_i, be_i, wdata_i stable until gnt_o.
- Simultaneous: req_i to an ACTIVE bank in the cycle its counter would hit IDLE_CYCLES -> access granted, counter cleared, stays ACTIVE.

## Timing
- Reset values: rvalid_o 0, rdata_o 0, sleep_o all 0, every bank ACTIVE with counter 0; gnt_o follows req_i.
- Read latency: 1 cycle from grant to rvalid_o.
- Access to sleeping bank: request in cycle t -> WAKE from t+1 -> gnt_o at t+1+WAKE_CYCLES.
- Back-to-back granted accesses sustain one per cycle.
- Reset assertion mid-WAKE or with a pending rvalid_o: banks return to ACTIVE, rvalid_o cleared immediately, pending response dropped.

## Configuration
- RAM_BYPASS_EN defined: bypass_en_i port exists; while high, granted writes do not modify memory and any granted transaction returns that cycle's wdata_i on rdata_o with rvalid_o one cycle later. Sleep FSM unaffected.
- RAM_BYPASS_EN undefined: no bypass_en_i port; always normal memory behaviour.

## Test plan
- Reset, write 0xDEADBEEF to 0x0 with be=0xF, read 0x0 -> gnt_o same cycle, rvalid_o next cycle with rdata_o 0xDEADBEEF.
- Write 0x11223344 to 0x4, then write 0xAABBCCDD with be=0x5, read -> 0x11BB33DD.
- Idle bank 1 for 16 cycles -> sleep_o[1]=1; request 0x2000 -> gnt_o 3 cycles later (WAKE_CYCLES=2), data retained.
- Request to bank 0 on cycle counter reaches 16 -> granted, sleep_o[0] stays 0.
- Deassert rstn_i during WAKE -> sleep_o 0, rvalid_o 0 asynchronously; next request granted same cycle.
- With RAM_BYPASS_EN, bypass_en_i=1, write 0x5A5A5A5A to 0x8 -> rdata_o 0x5A5A5A5A; bypass off, read 0x8 -> previous contents.
